// File: rtl/pipe_hazard_unit_pkg.sv
// Shared CPU pipeline types: forwarding-select encodings and the per-stage tracking record.
package pipe_hazard_unit_pkg;

  // Widest destination-register field a stage entry can hold (supports up to 64 registers).
  localparam int unsigned RD_MAX_W = 6;

  // EX operand source select.
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // What the hazard unit remembers about the instruction occupying a pipeline stage.
  typedef struct packed {
    logic                valid;
    logic                wr_en;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } stage_entry_t;

  localparam stage_entry_t STAGE_EMPTY = '{valid: 1'b0, wr_en: 1'b0, rd: '0, is_load: 1'b0};

  // True when the stage entry will write register r.
  function automatic logic writes_reg(input stage_entry_t e, input logic [RD_MAX_W-1:0] r);
    return e.valid && e.wr_en && (e.rd == r);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_port_cmp.sv
// Per-source-port compare: load-use hazard for the ID operand, forwarding select for the EX operand.
module hazard_port_cmp
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic [AW-1:0] id_rs_i,
  input  logic          id_rs_used_i,
  input  stage_entry_t  ex_i,
  input  stage_entry_t  mem_i,
  input  stage_entry_t  wb_i,
  input  logic [AW-1:0] ex_rs_i,
  input  logic          ex_rs_used_i,
  output logic          hazard_c_o,
  output fwd_sel_e      fwd_sel_c_o
);

  // With a two-cycle load latency a load sitting in MEM is still too young to forward.
  localparam logic CHECK_MEM = (LOAD_LAT >= 2);

  logic [RD_MAX_W-1:0] id_rs_ext;
  logic [RD_MAX_W-1:0] ex_rs_ext;
  logic                unused_wb_load;

  assign id_rs_ext      = RD_MAX_W'(id_rs_i);
  assign ex_rs_ext      = RD_MAX_W'(ex_rs_i);
  assign unused_wb_load = wb_i.is_load;

  // Load-use hazard: the ID operand waits on a load whose data is not yet forwardable.
  always_comb begin
    hazard_c_o = 1'b0;
    if (id_rs_used_i && (id_rs_i != '0)) begin
      if (writes_reg(ex_i, id_rs_ext) && ex_i.is_load) begin
        hazard_c_o = 1'b1;
      end
      if (CHECK_MEM && writes_reg(mem_i, id_rs_ext) && mem_i.is_load) begin
        hazard_c_o = 1'b1;
      end
    end
  end

  // Forwarding: youngest producer (MEM ALU result) wins over WB; r0 never forwards.
  always_comb begin
    fwd_sel_c_o = FWD_RF;
    if (ex_i.valid && ex_rs_used_i && (ex_rs_i != '0)) begin
      if (writes_reg(mem_i, ex_rs_ext) && !mem_i.is_load) begin
        fwd_sel_c_o = FWD_EXMEM;
      end else if (writes_reg(wb_i, ex_rs_ext)) begin
        fwd_sel_c_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: load-use stalls, taken-branch flushes, EX operand forwarding.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter  int unsigned NREG        = 32,
  parameter  int unsigned NRD         = 2,
  parameter  int unsigned LOAD_LAT    = 1,
  parameter  int unsigned FLUSH_DEPTH = 2,
  parameter  int unsigned CNT_W       = 16,
  localparam int unsigned AW          = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [NRD*AW-1:0]   id_rs,
  input  logic [NRD-1:0]      id_rs_used,
  input  logic                id_wr_en,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_is_load,
  input  logic                ex_br_taken,
  output logic                stall_if,
  output logic                bubble_ex,
  output logic                flush_ifid,
  output logic [2*NRD-1:0]    ex_fwd_sel,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned     FC_W         = 2;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  stage_entry_t        ex_q, ex_d;
  stage_entry_t        mem_q;
  stage_entry_t        wb_q;
  logic [NRD*AW-1:0]   ex_rs_q, ex_rs_d;
  logic [NRD-1:0]      ex_rs_used_q, ex_rs_used_d;
  logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [NRD-1:0]      port_hazard;
  fwd_sel_e            port_fwd [NRD];
  logic                flush_active;
  logic                load_use;

  // One compare slice per source port.
  for (genvar p = 0; p < NRD; p++) begin : g_port
    hazard_port_cmp #(
      .AW       (AW),
      .LOAD_LAT (LOAD_LAT)
    ) u_cmp (
      .id_rs_i      (id_rs[p*AW +: AW]),
      .id_rs_used_i (id_rs_used[p]),
      .ex_i         (ex_q),
      .mem_i        (mem_q),
      .wb_i         (wb_q),
      .ex_rs_i      (ex_rs_q[p*AW +: AW]),
      .ex_rs_used_i (ex_rs_used_q[p]),
      .hazard_c_o   (port_hazard[p]),
      .fwd_sel_c_o  (port_fwd[p])
    );
  end

  // Stall/flush control; a flush overrides a load-use stall, and reset forces everything quiet.
  always_comb begin
    flush_active = ex_br_taken || (flush_cnt_q != '0);
    load_use     = id_valid && (|port_hazard);
    stall_if     = rst_n && load_use && !flush_active;
    flush_ifid   = rst_n && flush_active;
    bubble_ex    = stall_if || flush_ifid;
  end

  // Pack per-port forwarding selects onto the output bus.
  always_comb begin
    ex_fwd_sel = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ex_fwd_sel[2*p +: 2] = rst_n ? port_fwd[p] : FWD_RF;
    end
  end

  // Next-state: ID->EX capture, flush countdown, saturating stall counter.
  always_comb begin
    ex_d         = STAGE_EMPTY;
    ex_rs_d      = '0;
    ex_rs_used_d = '0;
    flush_cnt_d  = flush_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    if (id_valid && !bubble_ex) begin
      ex_d.valid   = 1'b1;
      ex_d.wr_en   = id_wr_en;
      ex_d.rd      = RD_MAX_W'(id_rd);
      ex_d.is_load = id_is_load;
      ex_rs_d      = id_rs;
      ex_rs_used_d = id_rs_used;
    end

    if (ex_br_taken) begin
      flush_cnt_d = FLUSH_RELOAD;
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - FC_W'(1);
    end

    if (stall_if && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State advances on the falling edge together with the pipeline registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= STAGE_EMPTY;
      mem_q        <= STAGE_EMPTY;
      wb_q         <= STAGE_EMPTY;
      ex_rs_q      <= '0;
      ex_rs_used_q <= '0;
      flush_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= ex_q;
      wb_q         <= mem_q;
      ex_rs_q      <= ex_rs_d;
      ex_rs_used_q <= ex_rs_used_d;
      flush_cnt_q  <= flush_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 The block SHALL have parameter NREG, default 32, meaning the number of architectural registers; AW = clog2(NREG).
REQ-002 The block SHALL have parameter NRD, default 2, meaning the number of source-register ports per instruction.
REQ-003 The block SHALL have parameter LOAD_LAT, default 1, meaning the number of cycles after EX before load data can be forwarded (range 1..2).
REQ-004 The block SHALL have parameter FLUSH_DEPTH, default 2, meaning the number of cycles that wrong-path fetch slots are squashed after a taken branch (range 1..4).
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-006 clk  in  1  sole clock; all state changes on the negedge of clk, matching the pipeline registers.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 id_valid  in  1  the ID stage holds a real instruction.
REQ-009 id_rs  in  NRD*AW  source register numbers of the ID instruction.
REQ-010 id_rs_used  in  NRD  per-port flag: the source register is actually read.
REQ-011 id_wr_en / id_rd / id_is_load  in  1/AW/1  destination write enable, destination register, and load flag of the ID instruction.
REQ-012 ex_br_taken  in  1  the branch in EX resolved taken this cycle.
REQ-013 stall_if  out  1  hold PC and the IF/ID register.
REQ-014 bubble_ex  out  1  load a NOP, with all control signals 0, into ID/EX.
REQ-015 flush_ifid  out  1  replace the IF/ID content with a NOP.
REQ-016 ex_fwd_sel  out  2*NRD  per-port EX operand source: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB write data.
REQ-017 stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-018 The block SHALL track EX, MEM and WB stage entries, each holding {valid, wr_en, rd, is_load}; the EX entry SHALL additionally hold rs and rs_used per port.
REQ-019 On every negedge, the entries SHALL shift ID->EX->MEM->WB.
REQ-020 The ID->EX shift SHALL load an invalid entry when bubble_ex=1 or id_valid=0.
REQ-021 A hazard SHALL exist on port p when id_rs_used[p]=1, id_rs[p]!=0, and some stage k among the first LOAD_LAT stages after ID (EX, and MEM if LOAD_LAT=2) holds valid && wr_en && is_load && rd==id_rs[p].
REQ-022 Load-use stall: when a hazard exists, id_valid=1 and no flush is active, the block SHALL assert stall_if=1 and bubble_ex=1 combinationally in the same cycle.
REQ-023 The stall SHALL repeat each cycle until no hazard remains; LOAD_LAT=1 gives exactly 1 bubble, and LOAD_LAT=2 gives 2 bubbles for a back-to-back load-use pair.
REQ-024 Flush: when ex_br_taken=1, the block SHALL assert flush_ifid=1 and bubble_ex=1 in that cycle and load flush_cnt=FLUSH_DEPTH-1.
REQ-025 While flush_cnt!=0, the block SHALL assert flush_ifid=1 and bubble_ex=1, and decrement flush_cnt per negedge.
REQ-026 A new ex_br_taken while flush_cnt!=0 SHALL reload flush_cnt=FLUSH_DEPTH-1.
REQ-027 When flush and load-use stall coincide, flush SHALL win: stall_if=0 and stall_cnt SHALL NOT increment.
REQ-028 Forwarding for port p of the EX entry SHALL be: 1 if MEM is valid && wr_en && !is_load && rd==rs[p]; else 2 if WB is valid && wr_en && rd==rs[p]; else 0.
REQ-029 In forwarding, MEM SHALL have priority over WB.
REQ-030 Forwarding SHALL be 0 when rs[p]==0, when rs_used[p]==0, or when the EX entry is invalid.
REQ-031 stall_cnt SHALL increment by 1 on each negedge where stall_if=1, and SHALL saturate at all-ones.
REQ-032 All outputs except stall_cnt SHALL be combinational from state and inputs, with zero-cycle latency.

Reset
REQ-033 rst_n=0 SHALL immediately clear all stage valid bits, flush_cnt and stall_cnt.
REQ-034 During reset, outputs SHALL be stall_if=0, bubble_ex=0, flush_ifid=0, ex_fwd_sel=0 and stall_cnt=0.
REQ-035 Reset asserted mid-stall or mid-flush SHALL abandon that operation with no residual bubbles after release.

Structure
REQ-036 The forwarding-select encodings (FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2) and the stage-entry record type SHALL live in the shared cpu package.
REQ-037 Per-port compare logic SHALL be one sub-module, hazard_port_cmp, instantiated NRD times via generate.

Verification
REQ-038 Load-use: lw r3 followed immediately by add r4,r3,r5 (LOAD_LAT=1) -> exactly one cycle of stall_if=1/bubble_ex=1, then ex_fwd_sel port0=2, and stall_cnt=1.
REQ-039 ALU chain: add r2 then sub r6,r2,r2 -> no stall, and ex_fwd_sel = {1,1} when the sub is in EX.
REQ-040 Register 0 and priority: add r0 then add r7,r0,r1 -> ex_fwd_sel=0; add r2, add r2, then use r2 -> sel=1 (MEM priority over WB).
REQ-041 Branch: ex_br_taken pulse with FLUSH_DEPTH=3 -> flush_ifid high for 3 cycles; a second pulse in cycle 2 extends the flush to 4 cycles total.
REQ-042 Collision: load-use hazard and ex_br_taken in the same cycle -> flush_ifid=1, stall_if=0, and stall_cnt unchanged.
REQ-043 Reset during stall: rst_n low for 1 cycle while a stall is active -> all outputs 0 immediately and no bubble after release; stall_cnt saturation at CNT_W=4 holds at 15.
